// File: rtl/speed_reg_pkg.sv
// ---------------------------------------------------------------------------
// speed_reg_pkg : operating-mode encodings for param_shift_register
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package speed_reg_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;

endpackage : speed_reg_pkg

`default_nettype wire

// File: rtl/shift_next_mux.sv
// ---------------------------------------------------------------------------
// shift_next_mux : combinational next-value select for the shift register
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_next_mux
  import speed_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  q_i,
  input  logic [WIDTH-1:0]  d_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic              ser_in_l_i,
  input  logic              ser_in_r_i,
  output logic [WIDTH-1:0]  next_q_o
);

  always_comb begin
    next_q_o = q_i;
    case (mode_i)
      MODE_LOAD: next_q_o = d_i;
      MODE_SHL:  next_q_o = {q_i[WIDTH-2:0], ser_in_l_i};
      MODE_SHR:  next_q_o = {ser_in_r_i, q_i[WIDTH-1:1]};
      MODE_ROL:  next_q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ROR:  next_q_o = {q_i[0], q_i[WIDTH-1:1]};
      // HOLD and the two reserved codes keep the current value.
      default:   next_q_o = q_i;
    endcase
  end

endmodule : shift_next_mux

`default_nettype wire

// File: rtl/param_shift_register.sv
// ---------------------------------------------------------------------------
// param_shift_register : WIDTH-bit load/shift/rotate stage with change flag
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module param_shift_register
  import speed_reg_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}}
) (
  input  logic              CLK,
  input  logic              CLR_BAR,
  input  logic              PRE_BAR,
  input  logic              EN,
  input  logic [MODE_W-1:0] MODE,
  input  logic [WIDTH-1:0]  D,
  input  logic              SER_IN_L,
  input  logic              SER_IN_R,
  output logic [WIDTH-1:0]  Q,
  output logic [WIDTH-1:0]  Qbar,
  output logic              SER_OUT_L,
  output logic              SER_OUT_R,
  output logic              CHANGED
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] mux_next;
  logic             changed_q;

  shift_next_mux #(
    .WIDTH (WIDTH)
  ) u_next_mux (
    .q_i        (q_q),
    .d_i        (D),
    .mode_i     (MODE),
    .ser_in_l_i (SER_IN_L),
    .ser_in_r_i (SER_IN_R),
    .next_q_o   (mux_next)
  );

  // Preset outranks enable, which outranks the mode select.
  always_comb begin
    q_d = q_q;
    if (!PRE_BAR) begin
      q_d = PRESET_VALUE;
    end else if (EN) begin
      q_d = mux_next;
    end
  end

  always_ff @(posedge CLK or negedge CLR_BAR) begin
    if (!CLR_BAR) begin
      q_q       <= RESET_VALUE;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= (q_d != q_q);
    end
  end

  assign Q         = q_q;
  assign Qbar      = ~q_q;
  assign SER_OUT_L = q_q[WIDTH-1];
  assign SER_OUT_R = q_q[0];
  assign CHANGED   = changed_q;

endmodule : param_shift_register

`default_nettype wire

// File: tb/tb_param_shift_register.sv
// ---------------------------------------------------------------------------
// tb_param_shift_register : directed and random checks against a reference model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_param_shift_register;

  logic       CLK;
  logic       CLR_BAR;
  logic       PRE_BAR;
  logic       EN;
  logic [2:0] MODE;
  logic [7:0] D;
  logic       SER_IN_L;
  logic       SER_IN_R;
  logic [7:0] Q;
  logic [7:0] Qbar;
  logic       SER_OUT_L;
  logic       SER_OUT_R;
  logic       CHANGED;

  int vectors;
  int miscompares;

  int   mq;   // model register contents, 0..255
  logic mc;   // model change flag

  param_shift_register #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .CLR_BAR   (CLR_BAR),
    .PRE_BAR   (PRE_BAR),
    .EN        (EN),
    .MODE      (MODE),
    .D         (D),
    .SER_IN_L  (SER_IN_L),
    .SER_IN_R  (SER_IN_R),
    .Q         (Q),
    .Qbar      (Qbar),
    .SER_OUT_L (SER_OUT_L),
    .SER_OUT_R (SER_OUT_R),
    .CHANGED   (CHANGED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural next value computed with plain integer arithmetic.
  function automatic int ref_next(int q, logic pre_b, logic en, logic [2:0] mode,
                                  int d, logic sl, logic sr);
    if (!pre_b) return 255;
    if (!en) return q;
    case (mode)
      3'd1:    return d;
      3'd2:    return (q * 2) % 256 + int'(sl);
      3'd3:    return q / 2 + (sr ? 128 : 0);
      3'd4:    return (q * 2) % 256 + q / 128;
      3'd5:    return q / 2 + (q % 2) * 128;
      default: return q;
    endcase
  endfunction

  // Advance one clock edge and the model with it; sample 1 time unit later.
  task automatic tick();
    int nq;
    nq = ref_next(mq, PRE_BAR, EN, MODE, int'(D), SER_IN_L, SER_IN_R);
    @(posedge CLK);
    #1;
    mc = (nq != mq);
    mq = nq;
  endtask

  task automatic do_load(input logic [7:0] val);
    PRE_BAR = 1'b1; EN = 1'b1; MODE = 3'b001; D = val;
    tick();
  endtask

  task automatic test_reset();
    #2 CLR_BAR = 1'b0;
    #1;
    mq = 0; mc = 1'b0;
    vectors++;
    if (Q !== 8'h00) begin miscompares++; $display("FAIL reset_q: got %h want 00", Q); end
    vectors++;
    if (Qbar !== 8'hFF) begin miscompares++; $display("FAIL reset_qbar: got %h want ff", Qbar); end
    vectors++;
    if (CHANGED !== 1'b0 || SER_OUT_L !== 1'b0 || SER_OUT_R !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got ch=%b sl=%b sr=%b want 0 0 0", CHANGED, SER_OUT_L, SER_OUT_R);
    end
    @(posedge CLK); #3;
    CLR_BAR = 1'b1;
  endtask

  task automatic test_async_clear();
    do_load(8'hA5);
    vectors++;
    if (Q !== 8'hA5) begin miscompares++; $display("FAIL clr_preload: got %h want a5", Q); end
    #3 CLR_BAR = 1'b0;
    #1;
    mq = 0; mc = 1'b0;
    vectors++;
    if (Q !== 8'h00 || Qbar !== 8'hFF || CHANGED !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_async: got q=%h qbar=%h ch=%b want 00 ff 0", Q, Qbar, CHANGED);
    end
    #1 CLR_BAR = 1'b1;
    do_load(8'h3C);
    vectors++;
    if (Q !== 8'h3C || CHANGED !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_reload: got q=%h ch=%b want 3c 1", Q, CHANGED);
    end
    MODE = 3'b000;
    tick();
    vectors++;
    if (Q !== 8'h3C || CHANGED !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_changed_pulse: got q=%h ch=%b want 3c 0", Q, CHANGED);
    end
  endtask

  task automatic test_preset();
    do_load(8'h00);
    PRE_BAR = 1'b0; EN = 1'b0; MODE = 3'b001; D = 8'h12;
    tick();
    vectors++;
    if (Q !== 8'hFF || CHANGED !== 1'b1) begin
      miscompares++;
      $display("FAIL preset_priority: got q=%h ch=%b want ff 1", Q, CHANGED);
    end
    tick();
    vectors++;
    if (Q !== 8'hFF || CHANGED !== 1'b0) begin
      miscompares++;
      $display("FAIL preset_equal: got q=%h ch=%b want ff 0", Q, CHANGED);
    end
    PRE_BAR = 1'b1;
    do_load(8'hFF);
    vectors++;
    if (CHANGED !== 1'b0) begin
      miscompares++;
      $display("FAIL load_identical: got ch=%b want 0", CHANGED);
    end
  endtask

  task automatic test_shift();
    do_load(8'b1000_0001);
    MODE = 3'b010; SER_IN_L = 1'b1;
    #1;
    vectors++;
    if (SER_OUT_L !== 1'b1) begin miscompares++; $display("FAIL shl_tap: got %b want 1", SER_OUT_L); end
    tick();
    vectors++;
    if (Q !== 8'b0000_0011) begin miscompares++; $display("FAIL shl: got %b want 00000011", Q); end
    MODE = 3'b011; SER_IN_R = 1'b0;
    tick();
    vectors++;
    if (Q !== 8'b0000_0001) begin miscompares++; $display("FAIL shr: got %b want 00000001", Q); end
  endtask

  task automatic test_rotate();
    do_load(8'h81);
    MODE = 3'b100;
    tick();
    vectors++;
    if (Q !== 8'h03) begin miscompares++; $display("FAIL rol_wrap: got %h want 03", Q); end
    do_load(8'h5A);
    MODE = 3'b101;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (Q !== mq[7:0] || CHANGED !== mc) begin
        miscompares++;
        $display("FAIL ror_step%0d: got q=%h ch=%b want %h %b", i, Q, CHANGED, mq[7:0], mc);
      end
    end
    vectors++;
    if (Q !== 8'h5A) begin miscompares++; $display("FAIL ror_full_turn: got %h want 5a", Q); end
  endtask

  task automatic test_enable_reserved();
    do_load(8'hC3);
    EN = 1'b0; MODE = 3'b010; SER_IN_L = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (Q !== 8'hC3 || CHANGED !== 1'b0) begin
        miscompares++;
        $display("FAIL en_hold%0d: got q=%h ch=%b want c3 0", i, Q, CHANGED);
      end
    end
    EN = 1'b1; MODE = 3'b111; D = 8'h55;
    tick();
    vectors++;
    if ($isunknown(Q) || Q !== 8'hC3 || CHANGED !== 1'b0) begin
      miscompares++;
      $display("FAIL reserved_hold: got q=%h ch=%b want c3 0", Q, CHANGED);
    end
  endtask

  task automatic test_reset_mid_rotate();
    do_load(8'h81);
    MODE = 3'b100;
    tick();
    tick();
    #3 CLR_BAR = 1'b0;
    #1;
    mq = 0; mc = 1'b0;
    vectors++;
    if (Q !== 8'h00 || CHANGED !== 1'b0) begin
      miscompares++;
      $display("FAIL midrot_clear: got q=%h ch=%b want 00 0", Q, CHANGED);
    end
    #1 CLR_BAR = 1'b1;
    tick();
    vectors++;
    if (Q !== 8'h00 || CHANGED !== 1'b0) begin
      miscompares++;
      $display("FAIL midrot_first_rol: got q=%h ch=%b want 00 0", Q, CHANGED);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      PRE_BAR  = ($urandom_range(0, 7) != 0);
      EN       = ($urandom_range(0, 3) != 0);
      MODE     = 3'($urandom_range(0, 7));
      D        = 8'($urandom);
      SER_IN_L = 1'($urandom);
      SER_IN_R = 1'($urandom);
      tick();
      vectors++;
      if (Q !== mq[7:0] || CHANGED !== mc || Qbar !== ~mq[7:0] ||
          SER_OUT_L !== mq[7] || SER_OUT_R !== mq[0]) begin
        miscompares++;
        $display("FAIL random%0d: got q=%h qbar=%h ch=%b sl=%b sr=%b want q=%h ch=%b",
                 i, Q, Qbar, CHANGED, SER_OUT_L, SER_OUT_R, mq[7:0], mc);
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    mq = 0; mc = 1'b0;
    CLR_BAR = 1'b1; PRE_BAR = 1'b1; EN = 1'b0; MODE = 3'b000;
    D = 8'h00; SER_IN_L = 1'b0; SER_IN_R = 1'b0;
    test_reset();
    test_async_clear();
    test_preset();
    test_shift();
    test_rotate();
    test_enable_reserved();
    test_reset_mid_rotate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_param_shift_register

`default_nettype wire

// File: doc/param_shift_register.md
Name: param_shift_register

Overview:
- Parametrised WIDTH-bit register stage with asynchronous clear, synchronous preset, clock enable and six operating modes: hold, parallel load, shift left/right and rotate left/right.
- Used for speed-sample staging, serial sensor capture and setpoint holding in the speed controller datapath.
- Provides complementary output, serial taps at both ends and a registered change flag for downstream logic.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- PRESET_VALUE, {WIDTH{1'b1}}, value loaded by the synchronous preset.
- RESET_VALUE, {WIDTH{1'b0}}, value forced by the asynchronous clear.

Ports:
- CLK  input  1  rising-edge clock.
- CLR_BAR  input  1  asynchronous active-low reset/clear.
- PRE_BAR  input  1  synchronous active-low preset.
- EN  input  1  clock enable; when low, the register holds.
- MODE  input  3  operation select (encodings in package).
- D  input  WIDTH  parallel load data.
- SER_IN_L  input  1  serial input at the LSB side, used by shift left.
- SER_IN_R  input  1  serial input at the MSB side, used by shift right.
- Q  output  WIDTH  register contents.
- Qbar  output  WIDTH  bitwise complement of Q, combinational.
- SER_OUT_L  output  1  equals Q[WIDTH-1].
- SER_OUT_R  output  1  equals Q[0].
- CHANGED  output  1  registered; high for one cycle after any edge where Q took a new value.

Behaviour:
- Reset is asynchronous and active-low, port CLR_BAR; one clock, CLK.
- While CLR_BAR=0: Q=RESET_VALUE, CHANGED=0, Qbar=~RESET_VALUE, SER_OUT_L=RESET_VALUE[WIDTH-1], SER_OUT_R=RESET_VALUE[0]. All take effect immediately, with no clock required.
- Reset deassertion mid-operation: the first active edge uses the current inputs. No history survives reset.
- Priority at each rising CLK edge with CLR_BAR=1: PRE_BAR=0 > EN=0 > MODE.
- PRE_BAR=0: Q<=PRESET_VALUE regardless of EN or MODE.
- EN=0 (and PRE_BAR=1): Q holds.
- MODE encodings:
  - 000 HOLD: Q<=Q.
  - 001 LOAD: Q<=D.
  - 010 SHL: Q<={Q[WIDTH-2:0],SER_IN_L}.
  - 011 SHR: Q<={SER_IN_R,Q[WIDTH-1:1]}.
  - 100 ROL: Q<={Q[WIDTH-2:0],Q[WIDTH-1]}.
  - 101 ROR: Q<={Q[0],Q[WIDTH-1:1]}.
  - 110, 111 reserved: treated as HOLD; no X propagation.
- Latency: one cycle from input sample to Q. Qbar and both SER_OUT taps follow Q combinationally.
- CHANGED<=(next_Q != Q), evaluated at the same edge that updates Q.
  - Rises in the same cycle Q shows its new value; lasts exactly one cycle unless Q changes again.
  - Preset to an equal value, and LOAD of identical data, give CHANGED=0.
- Rotate wrap-around: the MSB re-enters at the LSB (ROL) and the LSB re-enters at the MSB (ROR). After WIDTH consecutive rotates, Q equals its original value.
- Shifts discard the bit shifted out. That bit is visible on the SER_OUT tap during the cycle before the shift.
- Simultaneous events: CLR_BAR=0 overrides all. PRE_BAR=0 with EN=1 and any MODE gives the preset.
- No internal state beyond Q and CHANGED.

Decomposition:
- Package speed_reg_pkg holds:
  - MODE localparams: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR.
  - MODE_W=3.
- One sub-module is natural: shift_next_mux.
  - Combinational; inputs are Q, D, MODE, SER_IN_L and SER_IN_R; output is next_Q.
  - The top level owns the flops, preset/enable priority and CHANGED.

Test Plan (WIDTH=8):
- Async clear: with Q=8'hA5, drop CLR_BAR between clock edges -> Q=8'h00 and Qbar=8'hFF immediately, CHANGED=0. Raise CLR_BAR, then LOAD D=8'h3C -> Q=8'h3C after 1 edge, CHANGED=1 for one cycle.
- Preset priority: Q=8'h00, PRE_BAR=0, EN=0, MODE=LOAD, D=8'h12 -> Q=8'hFF after the edge. Repeat with Q=8'hFF -> CHANGED=0.
- Shift with serial in: Q=8'b1000_0001, SHL with SER_IN_L=1 -> 8'b0000_0011, SER_OUT_L=1 before the edge. Then SHR with SER_IN_R=0 -> 8'b0000_0001.
- Rotate wrap: Q=8'h81, ROL once -> 8'h03. ROR 8 times from 8'h5A -> 8'h5A, with CHANGED=1 on every step except where the rotated value is equal.
- Enable/reserved: EN=0 with MODE=SHL for 5 cycles -> Q unchanged, CHANGED=0. MODE=3'b111 with EN=1 -> hold, no X on Q.
- Reset mid-rotate: assert CLR_BAR during a ROL sequence -> Q=8'h00 asynchronously. After release, the first ROL gives 8'h00 and CHANGED=0.
